// File: rtl/extbus_arbiter.sv
// Shares one async SRAM between the VPU, DMA and CPU. Each access is ADDR, SRAM_WAIT strobe cycles, then END.
// Priority is VPU > DMA > CPU, with a cap on VPU bursts and an override for a starved CPU.
module extbus_arbiter #(
  parameter int SRAM_WAIT        = 1,
  parameter int VPU_MAX_BURST    = 4,
  parameter int CPU_STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [16:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_hold,
  input  logic        vpu_req,
  input  logic [15:0] vpu_addr,
  output logic        vpu_ack,
  output logic [7:0]  vpu_rdata,
  input  logic        dma_req,
  input  logic [16:0] dma_addr,
  input  logic        dma_rw,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [16:0] sram_addr,
  input  logic [7:0]  sram_dq_i,
  output logic [7:0]  sram_dq_o,
  output logic        sram_dq_oe,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_cs2
);

  localparam int WW = $clog2(CPU_STARVE_LIMIT + 1);
  localparam int BW = $clog2(VPU_MAX_BURST + 1);
  localparam logic [WW-1:0] WAIT_LIM  = WW'(CPU_STARVE_LIMIT);
  localparam logic [BW-1:0] BURST_LIM = BW'(VPU_MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_STROBE, S_END} state_t;
  typedef enum logic [1:0] {OWN_CPU, OWN_VPU, OWN_DMA} owner_t;

  state_t        r_state;
  owner_t        r_owner;
  logic          r_rw;
  logic [2:0]    r_cnt;
  logic [WW-1:0] r_wait;
  logic [BW-1:0] r_burst;
  logic [16:0]   r_sram_addr;
  logic [7:0]    r_dq_o;
  logic          r_dq_oe, r_oe_n, r_we_n, r_cs2;
  logic [7:0]    r_cpu_rdata, r_vpu_rdata, r_dma_rdata;
  logic          r_vpu_ack, r_dma_ack;

  logic          w_cpu_done, w_cpu_hold, w_starve, w_vpu_ok, w_arb;
  logic          w_grant, w_gnt_rw;
  owner_t        w_gnt_owner;
  logic [16:0]   w_gnt_addr;
  logic [7:0]    w_gnt_wdata;

  assign w_cpu_done = (r_state == S_END) && (r_owner == OWN_CPU);
  assign w_cpu_hold = cpu_req && !w_cpu_done && !rst;
  assign w_starve   = cpu_req && (r_wait >= WAIT_LIM);
  // VPU is masked once its burst cap is reached, but only if someone else is waiting.
  assign w_vpu_ok   = vpu_req && !((r_burst >= BURST_LIM) && (dma_req || cpu_req));
  assign w_arb      = (r_state == S_IDLE) || (r_state == S_END);

  always_comb begin
    w_grant     = 1'b1;
    w_gnt_owner = OWN_CPU;
    w_gnt_addr  = cpu_addr;
    w_gnt_rw    = cpu_rw;
    w_gnt_wdata = cpu_wdata;
    if (w_starve) begin
      w_gnt_owner = OWN_CPU;
    end else if (w_vpu_ok) begin
      w_gnt_owner = OWN_VPU;
      w_gnt_addr  = {1'b0, vpu_addr};
      w_gnt_rw    = 1'b1;
      w_gnt_wdata = 8'h00;
    end else if (dma_req) begin
      w_gnt_owner = OWN_DMA;
      w_gnt_addr  = dma_addr;
      w_gnt_rw    = dma_rw;
      w_gnt_wdata = dma_wdata;
    end else if (!cpu_req) begin
      w_grant = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_CPU;
      r_rw        <= 1'b1;
      r_cnt       <= 3'd0;
      r_wait      <= '0;
      r_burst     <= '0;
      r_sram_addr <= 17'd0;
      r_dq_o      <= 8'h00;
      r_dq_oe     <= 1'b0;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_cs2       <= 1'b0;
      r_cpu_rdata <= 8'hFF;
      r_vpu_rdata <= 8'hFF;
      r_dma_rdata <= 8'hFF;
      r_vpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
    end else begin
      r_vpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      if (w_arb && w_grant && (w_gnt_owner == OWN_CPU))
        r_wait <= '0;
      else if (w_cpu_hold && (r_wait != '1))
        r_wait <= r_wait + 1'b1;

      case (r_state)
        S_IDLE, S_END: begin
          if (w_grant) begin
            r_state     <= S_ADDR;
            r_owner     <= w_gnt_owner;
            r_rw        <= w_gnt_rw;
            r_sram_addr <= w_gnt_addr;
            r_dq_o      <= w_gnt_wdata;
            r_dq_oe     <= !w_gnt_rw;
            r_cs2       <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            if (w_gnt_owner != OWN_VPU)
              r_burst <= '0;
            else if (r_burst != BURST_LIM)
              r_burst <= r_burst + 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_cs2   <= 1'b0;
            r_dq_oe <= 1'b0;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_burst <= '0;
          end
        end
        S_ADDR: begin
          r_state <= S_STROBE;
          r_cnt   <= 3'd1;
          r_oe_n  <= !r_rw;
          r_we_n  <= r_rw;
        end
        S_STROBE: begin
          if (r_cnt == 3'(SRAM_WAIT)) begin
            r_state <= S_END;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            case (r_owner)
              OWN_VPU: begin
                r_vpu_rdata <= sram_dq_i;
                r_vpu_ack   <= 1'b1;
              end
              OWN_DMA: begin
                if (r_rw) r_dma_rdata <= sram_dq_i;
                r_dma_ack <= 1'b1;
              end
              default: begin
                if (r_rw) r_cpu_rdata <= sram_dq_i;
              end
            endcase
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_rdata  = r_cpu_rdata;
  assign cpu_hold   = w_cpu_hold;
  assign vpu_ack    = r_vpu_ack;
  assign vpu_rdata  = r_vpu_rdata;
  assign dma_ack    = r_dma_ack;
  assign dma_rdata  = r_dma_rdata;
  assign sram_addr  = r_sram_addr;
  assign sram_dq_o  = r_dq_o;
  assign sram_dq_oe = r_dq_oe;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;
  assign sram_cs2   = r_cs2;

endmodule

// File: tb/tb_extbus_arbiter.sv
// Directed bench for extbus_arbiter with default parameters; the SRAM returns 5A at 0C123 and addr[7:0]^3C elsewhere.
module tb_extbus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_rw, vpu_req, dma_req, dma_rw;
  logic [16:0] cpu_addr, dma_addr;
  logic [15:0] vpu_addr;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic [7:0]  cpu_rdata, vpu_rdata, dma_rdata;
  logic        cpu_hold, vpu_ack, dma_ack;
  logic [16:0] sram_addr;
  logic [7:0]  sram_dq_i, sram_dq_o;
  logic        sram_dq_oe, sram_oe_n, sram_we_n, sram_cs2;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign sram_dq_i = (sram_addr == 17'h0C123) ? 8'h5A : (sram_addr[7:0] ^ 8'h3C);

  extbus_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .vpu_req(vpu_req), .vpu_addr(vpu_addr), .vpu_ack(vpu_ack), .vpu_rdata(vpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_rw(dma_rw), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_cs2(sram_cs2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic [31:0] pat;
  int          n_ev, run, max_run;

  initial begin
    rst = 1'b1; cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    vpu_req = 1'b0; vpu_addr = '0; dma_req = 1'b0; dma_rw = 1'b1; dma_addr = '0; dma_wdata = '0;
    tick(); tick();
    check("rst_cs2", sram_cs2, 0);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_we_n", sram_we_n, 1);
    check("rst_dq_oe", sram_dq_oe, 0);
    check("rst_cpu_rdata", cpu_rdata, 8'hFF);
    check("rst_vpu_rdata", vpu_rdata, 8'hFF);
    check("rst_dma_rdata", dma_rdata, 8'hFF);
    check("rst_vpu_ack", vpu_ack, 0);
    check("rst_dma_ack", dma_ack, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    cpu_req = 1'b0; rst = 1'b0;
    tick();

    // CPU read of 0C123
    cpu_req = 1'b1; cpu_addr = 17'h0C123; cpu_rw = 1'b1; #1;
    check("cpu_hold_idle", cpu_hold, 1);
    tick();
    check("cpu_addr_cs2", sram_cs2, 1);
    check("cpu_addr_oe_n", sram_oe_n, 1);
    check("cpu_addr_bus", sram_addr, 17'h0C123);
    check("cpu_addr_hold", cpu_hold, 1);
    tick();
    check("cpu_strobe_oe_n", sram_oe_n, 0);
    check("cpu_strobe_hold", cpu_hold, 1);
    tick();
    check("cpu_end_hold", cpu_hold, 0);
    check("cpu_end_rdata", cpu_rdata, 8'h5A);
    check("cpu_end_oe_n", sram_oe_n, 1);
    cpu_req = 1'b0;
    tick();
    check("idle_cs2", sram_cs2, 0);
    check("idle_addr_held", sram_addr, 17'h0C123);
    check("cpu_rdata_held", cpu_rdata, 8'h5A);

    // VPU and CPU on the same edge
    vpu_req = 1'b1; vpu_addr = 16'h1234; cpu_req = 1'b1; cpu_addr = 17'h00010; cpu_rw = 1'b1;
    tick();
    check("vc_first_vpu", sram_addr, 17'h01234);
    tick(); tick();
    check("vc_vpu_ack", vpu_ack, 1);
    check("vc_vpu_rdata", vpu_rdata, 8'h08);
    vpu_req = 1'b0;
    tick();
    check("vc_cpu_addr", sram_addr, 17'h00010);
    check("vc_cpu_cs2", sram_cs2, 1);
    check("vc_vpu_ack_pulse", vpu_ack, 0);
    tick(); tick();
    check("vc_cpu_hold", cpu_hold, 0);
    check("vc_cpu_rdata", cpu_rdata, 8'h2C);
    cpu_req = 1'b0;
    tick();

    // DMA write A5 to 1FFFF
    dma_req = 1'b1; dma_rw = 1'b0; dma_wdata = 8'hA5; dma_addr = 17'h1FFFF;
    tick();
    check("dw_addr_dq_oe", sram_dq_oe, 1);
    check("dw_addr_we_n", sram_we_n, 1);
    check("dw_dq_o", sram_dq_o, 8'hA5);
    check("dw_addr_bus", sram_addr, 17'h1FFFF);
    tick();
    check("dw_strobe_we_n", sram_we_n, 0);
    check("dw_strobe_oe_n", sram_oe_n, 1);
    check("dw_strobe_dq_oe", sram_dq_oe, 1);
    tick();
    check("dw_end_ack", dma_ack, 1);
    check("dw_end_we_n", sram_we_n, 1);
    check("dw_end_dq_oe", sram_dq_oe, 1);
    dma_req = 1'b0;
    tick();
    check("dw_idle_ack", dma_ack, 0);
    check("dw_idle_dq_oe", sram_dq_oe, 0);
    check("dw_idle_cs2", sram_cs2, 0);

    // DMA read whose request drops right after grant still completes
    dma_req = 1'b1; dma_rw = 1'b1; dma_addr = 17'h00033;
    tick();
    dma_req = 1'b0;
    tick(); tick();
    check("dr_ack", dma_ack, 1);
    check("dr_rdata", dma_rdata, 8'h0F);
    tick();
    check("dr_no_regrant", sram_cs2, 0);

    // VPU and CPU held: four VPU then one CPU, repeating
    vpu_req = 1'b1; vpu_addr = 16'h0200; cpu_req = 1'b1; cpu_addr = 17'h00400; cpu_rw = 1'b1; #1;
    pat = 0; n_ev = 0; run = 0; max_run = 0;
    for (int i = 0; i < 31; i++) begin
      if (cpu_hold) begin
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      if (vpu_ack) begin pat = pat << 1; n_ev++; end
      if (sram_cs2 && cpu_req && !cpu_hold) begin pat = (pat << 1) | 1; n_ev++; end
      if (i < 30) tick();
    end
    check("burst_events", n_ev, 10);
    check("burst_pattern", pat, 32'b0000100001);
    check("burst_cpu_max_wait", max_run, 15);
    vpu_req = 1'b0; cpu_req = 1'b0;
    tick();

    // Reset in the middle of a DMA read strobe
    dma_req = 1'b1; dma_rw = 1'b1; dma_addr = 17'h00077;
    tick(); tick();
    check("ra_strobe_oe_n", sram_oe_n, 0);
    rst = 1'b1;
    tick();
    check("ra_oe_n", sram_oe_n, 1);
    check("ra_we_n", sram_we_n, 1);
    check("ra_cs2", sram_cs2, 0);
    check("ra_dq_oe", sram_dq_oe, 0);
    check("ra_no_ack", dma_ack, 0);
    check("ra_dma_rdata", dma_rdata, 8'hFF);
    check("ra_cpu_rdata", cpu_rdata, 8'hFF);
    dma_req = 1'b0; rst = 1'b0;
    tick();
    check("ra_no_late_ack", dma_ack, 0);

    // All three held: CPU starves until its wait count reaches the limit
    vpu_req = 1'b1; vpu_addr = 16'h0300;
    dma_req = 1'b1; dma_rw = 1'b1; dma_addr = 17'h00500;
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 17'h00600; #1;
    pat = 0; n_ev = 0;
    for (int i = 0; i < 60; i++) begin
      if (vpu_ack) begin pat = (pat << 2) | 1; n_ev++; end
      if (dma_ack) begin pat = (pat << 2) | 2; n_ev++; end
      if (sram_cs2 && cpu_req && !cpu_hold) begin pat = (pat << 2) | 3; n_ev++; end
      if (n_ev >= 7) break;
      tick();
    end
    check("starve_events", n_ev, 7);
    check("starve_pattern", pat, 32'b01_01_01_01_10_01_11);
    vpu_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0;
    tick(); tick(); tick();
    check("quiet_cs2", sram_cs2, 0);
    check("quiet_hold", cpu_hold, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
